// File: rtl/display_scan_driver.sv
// Purpose : time-multiplexed scan driver for a multi-digit seven-segment display
//           (feeds value/mode to the segment decoder, drives one-hot digit enables).
// Latency : outputs are registered; each cycle's outputs describe that cycle's slot position.
// Backpressure: none -- free-running scan; inputs are sampled once per frame.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   digit_values 4-bit code per digit, digit i at [4i+3:4i], digit 0 scanned first
//   digit_modes  per-digit decoder mode (0 = number, 1 = alphabet)
//   blink_mask   per-digit blink enable
//   value/mode   code and mode presented to the decoder
//   digit_en     one-hot digit enable, all-zero during the blanking gap
//   frame_done   one-cycle pulse on the last cycle of each frame
module display_scan_driver #(
  parameter int NUM_DIGITS   = 6,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digit_values,
  input  logic [NUM_DIGITS-1:0]   digit_modes,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [3:0]              value,
  output logic                    mode,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int CNT_W = (PRESCALE > 1)     ? $clog2(PRESCALE)     : 1;
  localparam int IDX_W = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  // Current state
  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [BLK_W-1:0]        blink_cnt;
  logic                    blink_phase;
  logic [4*NUM_DIGITS-1:0] shadow_values;
  logic [NUM_DIGITS-1:0]   shadow_modes;
  logic [NUM_DIGITS-1:0]   shadow_mask;

  // Next state
  state_t                  state_nxt;
  logic [CNT_W-1:0]        cnt_nxt;
  logic [IDX_W-1:0]        idx_nxt;
  logic [BLK_W-1:0]        blink_cnt_nxt;
  logic                    blink_phase_nxt;
  logic [4*NUM_DIGITS-1:0] shadow_values_nxt;
  logic [NUM_DIGITS-1:0]   shadow_modes_nxt;
  logic [NUM_DIGITS-1:0]   shadow_mask_nxt;

  // Next outputs
  logic [3:0]              value_nxt;
  logic                    mode_nxt;
  logic [NUM_DIGITS-1:0]   digit_en_nxt;
  logic                    frame_done_nxt;

  logic                    frame_end;
  logic                    slot_end;
  logic                    blanked_nxt;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // State register (also holds the registered outputs)
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_BLANK;
      cnt           <= '0;
      idx           <= '0;
      blink_cnt     <= '0;
      blink_phase   <= 1'b0;
      shadow_values <= '0;
      shadow_modes  <= '0;
      shadow_mask   <= '0;
      value         <= '0;
      mode          <= 1'b0;
      digit_en      <= '0;
      frame_done    <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      idx           <= idx_nxt;
      blink_cnt     <= blink_cnt_nxt;
      blink_phase   <= blink_phase_nxt;
      shadow_values <= shadow_values_nxt;
      shadow_modes  <= shadow_modes_nxt;
      shadow_mask   <= shadow_mask_nxt;
      value         <= value_nxt;
      mode          <= mode_nxt;
      digit_en      <= digit_en_nxt;
      frame_done    <= frame_done_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt         = state;
    cnt_nxt           = cnt + CNT_W'(1);
    idx_nxt           = idx;
    blink_cnt_nxt     = blink_cnt;
    blink_phase_nxt   = blink_phase;
    shadow_values_nxt = shadow_values;
    shadow_modes_nxt  = shadow_modes;
    shadow_mask_nxt   = shadow_mask;

    case (state)
      ST_BLANK: if (cnt == BLANK_END) state_nxt = ST_SHOW;
      ST_SHOW:  if (slot_end)         state_nxt = ST_BLANK;
      default:                        state_nxt = ST_BLANK;
    endcase

    if (slot_end) begin
      cnt_nxt = '0;
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end

    // Frame boundary: snapshot inputs and advance blink timing together, so a
    // new frame always sees one consistent set of codes, modes and phase.
    if (frame_end) begin
      shadow_values_nxt = digit_values;
      shadow_modes_nxt  = digit_modes;
      shadow_mask_nxt   = blink_mask;
      if (blink_cnt == BLK_LAST) begin
        blink_cnt_nxt   = '0;
        blink_phase_nxt = ~blink_phase;
      end else begin
        blink_cnt_nxt   = blink_cnt + BLK_W'(1);
      end
    end
  end

  // Output logic: computed from next-state values so the registered outputs
  // line up with the cycle whose cnt/idx they describe.
  always_comb begin
    blanked_nxt    = blink_phase_nxt && shadow_mask_nxt[idx_nxt];
    value_nxt      = shadow_values_nxt[4*int'(idx_nxt) +: 4];
    mode_nxt       = shadow_modes_nxt[idx_nxt];
    digit_en_nxt   = '0;
    frame_done_nxt = (idx_nxt == IDX_LAST) && (cnt_nxt == CNT_LAST);

    if (state_nxt == ST_SHOW) begin
      digit_en_nxt = NUM_DIGITS'(1) << idx_nxt;
    end

    // Blink-off slot: dark for the whole slot, decoder shown an alphabet space.
    if (blanked_nxt) begin
      digit_en_nxt = '0;
      value_nxt    = 4'b0000;
      mode_nxt     = 1'b1;
    end
  end

endmodule

// File: tb/tb_display_scan_driver.sv
// Bench for display_scan_driver with a small frame geometry. A timing model
// derived from cycles-since-reset predicts every output each cycle; expected
// records are queued at the clock edge and checked on the following falling edge.
module tb_display_scan_driver;

  localparam int N  = 4;
  localparam int P  = 8;
  localparam int B  = 2;
  localparam int BF = 2;
  localparam int NP = N * P;

  logic           clk = 1'b0;
  logic           reset;
  logic [4*N-1:0] vals;
  logic [N-1:0]   modes;
  logic [N-1:0]   mask;
  logic [3:0]     value;
  logic           mode;
  logic [N-1:0]   digit_en;
  logic           frame_done;

  always #5 clk = ~clk;

  display_scan_driver #(
    .NUM_DIGITS  (N),
    .PRESCALE    (P),
    .BLANK_CYCLES(B),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .digit_values(vals),
    .digit_modes (modes),
    .blink_mask  (mask),
    .value       (value),
    .mode        (mode),
    .digit_en    (digit_en),
    .frame_done  (frame_done)
  );

  typedef struct packed {
    logic [N-1:0] en;
    logic [3:0]   val;
    logic         md;
    logic         fd;
  } exp_t;

  exp_t     sb[$];
  int       checks = 0;
  int       errors = 0;

  // Model state: cycles since reset and the frame's latched inputs.
  int       t = 0;
  logic [4*N-1:0] sh_vals  = '0;
  logic [N-1:0]   sh_modes = '0;
  logic [N-1:0]   sh_mask  = '0;

  function automatic exp_t predict(input int tt);
    exp_t e;
    int   frame, pos, slot;
    logic phase, blank;
    frame = tt / NP;
    pos   = tt % P;
    slot  = (tt / P) % N;
    phase = ((frame / BF) % 2) == 1;
    blank = phase && sh_mask[slot];
    e.en  = (pos >= B && !blank) ? N'(1 << slot) : '0;
    e.val = blank ? 4'd0 : sh_vals[slot*4 +: 4];
    e.md  = blank ? 1'b1 : sh_modes[slot];
    e.fd  = (tt % NP) == NP - 1;
    return e;
  endfunction

  task automatic step(input logic r);
    exp_t e;
    reset = r;
    @(posedge clk);
    if (r) begin
      t        = 0;
      sh_vals  = '0;
      sh_modes = '0;
      sh_mask  = '0;
    end else begin
      if ((t % NP) == NP - 1) begin
        sh_vals  = vals;
        sh_modes = modes;
        sh_mask  = mask;
      end
      t = t + 1;
    end
    sb.push_back(predict(t));
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    assert (digit_en === e.en) else begin
      errors++;
      $error("FAIL digit_en t=%0d got %b exp %b", t, digit_en, e.en);
    end
    checks++;
    assert (value === e.val) else begin
      errors++;
      $error("FAIL value t=%0d got %0d exp %0d", t, value, e.val);
    end
    checks++;
    assert (mode === e.md) else begin
      errors++;
      $error("FAIL mode t=%0d got %b exp %b", t, mode, e.md);
    end
    checks++;
    assert (frame_done === e.fd) else begin
      errors++;
      $error("FAIL frame_done t=%0d got %b exp %b", t, frame_done, e.fd);
    end
    checks++;
    assert ($onehot0(digit_en) === 1'b1) else begin
      errors++;
      $error("FAIL onehot t=%0d got %b exp at most one bit", t, digit_en);
    end
  endtask

  task automatic run_to(input int target);
    while (t < target) step(1'b0);
  endtask

  initial begin
    reset = 1'b1;
    vals  = '0;
    modes = '0;
    mask  = '0;

    // Reset held three cycles: outputs all zero.
    repeat (3) step(1'b1);

    // Codes 1,2,3,4 presented before the first frame ends; frame 0 shows zeros.
    vals  = {4'd4, 4'd3, 4'd2, 4'd1};
    modes = 4'b0000;
    run_to(39);

    // Mid-frame change must not tear frame 1; frame 2 shows all 9s.
    vals = {4'd9, 4'd9, 4'd9, 4'd9};
    run_to(96);

    // Alphabet codes, digit 1 blinking: frames 4-5 normal, 6-7 blanked digit 1.
    vals  = {4'd12, 4'd11, 4'd6, 4'd5};
    modes = 4'b1111;
    mask  = 4'b0010;
    run_to(NP * 8 + 3);

    // Mid-frame reset during digit 2 SHOW, then a fresh blink cycle.
    step(1'b1);
    run_to(20);
    step(1'b1);
    run_to(NP * 6 + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
